ct_ifu_l0_btb_array: RTL and testbench

// - Parametrised fully-associative L0 BTB: NUM_ENTRY entries with tag, target, way_pred,
//   ras flag and a CNT_W-bit saturating direction counter.
// - Sits in IFU IF stage beside the main BTB; gives 1-cycle-latency target prediction.
// - Adds over the single-entry design: internal lookup/CAM, allocate-on-miss with a

---
 rtl/ct_ifu_l0btb_pkg.sv | 31 +++
 rtl/ct_ifu_l0btb_entry_param.sv | 62 ++++++
 rtl/ct_ifu_l0_btb_array.sv | 135 +++++++++++++
 tb/tb_ct_ifu_l0_btb_array.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_ifu_l0btb_pkg.sv
// rtl/ct_ifu_l0btb_pkg.sv - L0 BTB configuration, entry layout and counter helper
package ct_ifu_l0btb_pkg;

    localparam int NUM_ENTRY = 16;
    localparam int TAG_W     = 15;
    localparam int TGT_W     = 20;
    localparam int WAY_W     = 2;
    localparam int CNT_W     = 2;
    localparam int IDX_W     = $clog2(NUM_ENTRY);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1 << (CNT_W - 1));

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [TGT_W-1:0] target;
        logic [WAY_W-1:0] way;
        logic             ras;
        logic [CNT_W-1:0] cnt;
    } l0btb_entry_t;

    function automatic logic [CNT_W-1:0] sat_cnt_upd(input logic [CNT_W-1:0] cnt,
                                                     input logic             taken);
        if (taken) begin
            return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
        return (cnt == '0) ? cnt : cnt - 1'b1;
    endfunction

endpackage

// File: rtl/ct_ifu_l0btb_entry_param.sv
// rtl/ct_ifu_l0btb_entry_param.sv - one L0 BTB entry: storage, tag compares, gated write
module ct_ifu_l0btb_entry_param
    import ct_ifu_l0btb_pkg::*;
(
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             inv_all,
    input  logic             entry_alloc,
    input  logic             entry_upd,
    input  logic [TAG_W-1:0] lkup_tag,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic [TGT_W-1:0] upd_target,
    input  logic [WAY_W-1:0] upd_way_pred,
    input  logic             upd_ras,
    input  logic             upd_taken,
    output logic             entry_vld,
    output logic             entry_lkup_hit,
    output logic             entry_upd_hit,
    output logic [TGT_W-1:0] entry_target,
    output logic [WAY_W-1:0] entry_way_pred,
    output logic             entry_ras,
    output logic             entry_taken
);

    l0btb_entry_t entry_q;
    logic         local_en;

    // local_en is the entry's clock-gate enable: the registers only move on a
    // write to this entry, a global invalidate, or reset.
    assign local_en = entry_alloc | entry_upd | inv_all | cpurst;

    always_ff @(posedge forever_cpuclk) begin
        if (local_en) begin
            if (cpurst) begin
                entry_q <= '0;
            end else if (inv_all) begin
                entry_q.vld <= 1'b0;
            end else if (entry_alloc) begin
                entry_q.vld    <= 1'b1;
                entry_q.tag    <= upd_tag;
                entry_q.target <= upd_target;
                entry_q.way    <= upd_way_pred;
                entry_q.ras    <= upd_ras;
                entry_q.cnt    <= CNT_INIT;
            end else begin
                entry_q.target <= upd_target;
                entry_q.way    <= upd_way_pred;
                entry_q.ras    <= upd_ras;
                entry_q.cnt    <= sat_cnt_upd(entry_q.cnt, upd_taken);
            end
        end
    end

    assign entry_vld      = entry_q.vld;
    assign entry_lkup_hit = entry_q.vld & (entry_q.tag == lkup_tag);
    assign entry_upd_hit  = entry_q.vld & (entry_q.tag == upd_tag);
    assign entry_target   = entry_q.target;
    assign entry_way_pred = entry_q.way;
    assign entry_ras      = entry_q.ras;
    assign entry_taken    = entry_q.cnt[CNT_W-1];

endmodule

// File: rtl/ct_ifu_l0_btb_array.sv
// rtl/ct_ifu_l0_btb_array.sv - fully-associative L0 BTB with round-robin allocate and training
module ct_ifu_l0_btb_array
    import ct_ifu_l0btb_pkg::*;
(
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             cp0_ifu_btb_en,
    input  logic             cp0_ifu_l0btb_en,
    input  logic             inv_all,
    input  logic             lkup_vld,
    input  logic [TAG_W-1:0] lkup_tag,
    output logic             lkup_hit,
    output logic [IDX_W-1:0] lkup_idx,
    output logic [TGT_W-1:0] lkup_target,
    output logic [WAY_W-1:0] lkup_way_pred,
    output logic             lkup_ras,
    output logic             lkup_taken,
    input  logic             upd_vld,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic [TGT_W-1:0] upd_target,
    input  logic [WAY_W-1:0] upd_way_pred,
    input  logic             upd_ras,
    input  logic             upd_taken
);

    logic                 func_en;
    logic                 upd_en;
    logic                 lkup_req;
    logic                 alloc_en;
    logic [NUM_ENTRY-1:0] vld_vec;
    logic [NUM_ENTRY-1:0] lkup_hit_vec;
    logic [NUM_ENTRY-1:0] upd_hit_vec;
    logic [NUM_ENTRY-1:0] upd_hit_oh;
    logic [NUM_ENTRY-1:0] first_inv_oh;
    logic [NUM_ENTRY-1:0] victim_oh;
    logic [NUM_ENTRY-1:0] alloc_oh;
    logic [NUM_ENTRY-1:0] entry_alloc;
    logic [NUM_ENTRY-1:0] entry_upd;
    logic [TGT_W-1:0]     target_arr [NUM_ENTRY];
    logic [WAY_W-1:0]     way_arr    [NUM_ENTRY];
    logic [NUM_ENTRY-1:0] ras_vec;
    logic [NUM_ENTRY-1:0] taken_vec;
    logic [IDX_W-1:0]     victim_ptr;

    logic                 hit_any;
    logic [IDX_W-1:0]     hit_idx;
    logic [TGT_W-1:0]     hit_target;
    logic [WAY_W-1:0]     hit_way;
    logic                 hit_ras;
    logic                 hit_taken;

    assign func_en  = cp0_ifu_btb_en & cp0_ifu_l0btb_en;
    assign upd_en   = upd_vld & func_en & ~inv_all;
    assign lkup_req = lkup_vld & func_en & ~inv_all;

    // Lowest-set isolation keeps a (theoretically impossible) duplicate tag from
    // writing two entries at once.
    assign upd_hit_oh   = upd_hit_vec & (~upd_hit_vec + 1'b1);
    assign first_inv_oh = ~vld_vec & (vld_vec + 1'b1);
    assign victim_oh    = {{(NUM_ENTRY-1){1'b0}}, 1'b1} << victim_ptr;
    assign alloc_oh     = (&vld_vec) ? victim_oh : first_inv_oh;
    assign alloc_en     = upd_en & ~(|upd_hit_vec) & upd_taken;
    assign entry_alloc  = {NUM_ENTRY{alloc_en}} & alloc_oh;
    assign entry_upd    = {NUM_ENTRY{upd_en}} & upd_hit_oh;

    for (genvar i = 0; i < NUM_ENTRY; i++) begin : g_entry
        ct_ifu_l0btb_entry_param u_entry (
            .forever_cpuclk (forever_cpuclk),
            .cpurst         (cpurst),
            .inv_all        (inv_all),
            .entry_alloc    (entry_alloc[i]),
            .entry_upd      (entry_upd[i]),
            .lkup_tag       (lkup_tag),
            .upd_tag        (upd_tag),
            .upd_target     (upd_target),
            .upd_way_pred   (upd_way_pred),
            .upd_ras        (upd_ras),
            .upd_taken      (upd_taken),
            .entry_vld      (vld_vec[i]),
            .entry_lkup_hit (lkup_hit_vec[i]),
            .entry_upd_hit  (upd_hit_vec[i]),
            .entry_target   (target_arr[i]),
            .entry_way_pred (way_arr[i]),
            .entry_ras      (ras_vec[i]),
            .entry_taken    (taken_vec[i])
        );
    end

    // Pointer only advances when the victim was actually consumed (array full).
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst || inv_all) begin
            victim_ptr <= '0;
        end else if (alloc_en && (&vld_vec)) begin
            victim_ptr <= victim_ptr + 1'b1;
        end
    end

    always_comb begin
        hit_any    = 1'b0;
        hit_idx    = '0;
        hit_target = '0;
        hit_way    = '0;
        hit_ras    = 1'b0;
        hit_taken  = 1'b0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (lkup_hit_vec[i]) begin
                hit_any    = 1'b1;
                hit_idx    = IDX_W'(i);
                hit_target = target_arr[i];
                hit_way    = way_arr[i];
                hit_ras    = ras_vec[i];
                hit_taken  = taken_vec[i];
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst || !(lkup_req && hit_any)) begin
            lkup_hit      <= 1'b0;
            lkup_idx      <= '0;
            lkup_target   <= '0;
            lkup_way_pred <= '0;
            lkup_ras      <= 1'b0;
            lkup_taken    <= 1'b0;
        end else begin
            lkup_hit      <= 1'b1;
            lkup_idx      <= hit_idx;
            lkup_target   <= hit_target;
            lkup_way_pred <= hit_way;
            lkup_ras      <= hit_ras;
            lkup_taken    <= hit_taken;
        end
    end

endmodule

// File: tb/tb_ct_ifu_l0_btb_array.sv
// tb/tb_ct_ifu_l0_btb_array.sv - self-checking bench for the L0 BTB array
module tb_ct_ifu_l0_btb_array;
    import ct_ifu_l0btb_pkg::*;

    localparam int RW = 3 + IDX_W + TGT_W + WAY_W;

    logic             forever_cpuclk = 1'b0;
    logic             cpurst;
    logic             cp0_ifu_btb_en;
    logic             cp0_ifu_l0btb_en;
    logic             inv_all;
    logic             lkup_vld;
    logic [TAG_W-1:0] lkup_tag;
    logic             lkup_hit;
    logic [IDX_W-1:0] lkup_idx;
    logic [TGT_W-1:0] lkup_target;
    logic [WAY_W-1:0] lkup_way_pred;
    logic             lkup_ras;
    logic             lkup_taken;
    logic             upd_vld;
    logic [TAG_W-1:0] upd_tag;
    logic [TGT_W-1:0] upd_target;
    logic [WAY_W-1:0] upd_way_pred;
    logic             upd_ras;
    logic             upd_taken;

    int checks = 0;
    int errors = 0;

    always #5 forever_cpuclk = ~forever_cpuclk;

    ct_ifu_l0_btb_array dut (
        .forever_cpuclk   (forever_cpuclk),
        .cpurst           (cpurst),
        .cp0_ifu_btb_en   (cp0_ifu_btb_en),
        .cp0_ifu_l0btb_en (cp0_ifu_l0btb_en),
        .inv_all          (inv_all),
        .lkup_vld         (lkup_vld),
        .lkup_tag         (lkup_tag),
        .lkup_hit         (lkup_hit),
        .lkup_idx         (lkup_idx),
        .lkup_target      (lkup_target),
        .lkup_way_pred    (lkup_way_pred),
        .lkup_ras         (lkup_ras),
        .lkup_taken       (lkup_taken),
        .upd_vld          (upd_vld),
        .upd_tag          (upd_tag),
        .upd_target       (upd_target),
        .upd_way_pred     (upd_way_pred),
        .upd_ras          (upd_ras),
        .upd_taken        (upd_taken)
    );

    wire [RW-1:0] obs = {lkup_hit, lkup_idx, lkup_target, lkup_way_pred, lkup_ras, lkup_taken};

    // Reference model: a plain table of entries plus a replacement pointer.
    bit m_vld [NUM_ENTRY];
    int m_tag [NUM_ENTRY];
    int m_tgt [NUM_ENTRY];
    int m_way [NUM_ENTRY];
    bit m_ras [NUM_ENTRY];
    int m_cnt [NUM_ENTRY];
    int m_ptr;

    function automatic void model_reset();
        for (int i = 0; i < NUM_ENTRY; i++) begin
            m_vld[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_way[i] = 0; m_ras[i] = 0; m_cnt[i] = 0;
        end
        m_ptr = 0;
    endfunction

    function automatic void model_invalidate();
        for (int i = 0; i < NUM_ENTRY; i++) m_vld[i] = 0;
        m_ptr = 0;
    endfunction

    function automatic void model_update(input int tag, input int tgt, input int way,
                                         input bit ras, input bit taken);
        int slot = -1;
        int cmax = (1 << CNT_W) - 1;
        for (int i = 0; i < NUM_ENTRY; i++)
            if (slot < 0 && m_vld[i] && m_tag[i] == tag) slot = i;
        if (slot >= 0) begin
            m_tgt[slot] = tgt; m_way[slot] = way; m_ras[slot] = ras;
            if (taken) m_cnt[slot] = (m_cnt[slot] < cmax) ? m_cnt[slot] + 1 : cmax;
            else       m_cnt[slot] = (m_cnt[slot] > 0) ? m_cnt[slot] - 1 : 0;
            return;
        end
        if (!taken) return;
        for (int i = 0; i < NUM_ENTRY; i++)
            if (slot < 0 && !m_vld[i]) slot = i;
        if (slot < 0) begin
            slot = m_ptr;
            m_ptr = (m_ptr + 1) % NUM_ENTRY;
        end
        m_vld[slot] = 1; m_tag[slot] = tag; m_tgt[slot] = tgt; m_way[slot] = way;
        m_ras[slot] = ras; m_cnt[slot] = 1 << (CNT_W - 1);
    endfunction

    function automatic logic [RW-1:0] exp_lkup(input int tag);
        for (int i = 0; i < NUM_ENTRY; i++)
            if (m_vld[i] && m_tag[i] == tag)
                return {1'b1, IDX_W'(i), TGT_W'(m_tgt[i]), WAY_W'(m_way[i]), m_ras[i],
                        m_cnt[i] >= (1 << (CNT_W - 1))};
        return '0;
    endfunction

    task automatic tick();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic lookup(input int tag);
        lkup_vld = 1'b1;
        lkup_tag = TAG_W'(tag);
        tick();
        lkup_vld = 1'b0;
    endtask

    task automatic update(input int tag, input int tgt, input int way, input bit ras, input bit taken);
        upd_vld      = 1'b1;
        upd_tag      = TAG_W'(tag);
        upd_target   = TGT_W'(tgt);
        upd_way_pred = WAY_W'(way);
        upd_ras      = ras;
        upd_taken    = taken;
        tick();
        upd_vld = 1'b0;
        if (cp0_ifu_btb_en && cp0_ifu_l0btb_en) model_update(tag, tgt, way, ras, taken);
    endtask

    task automatic do_reset();
        cpurst = 1'b1;
        tick();
        tick();
        cpurst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        cpurst = 1'b1; cp0_ifu_btb_en = 1'b1; cp0_ifu_l0btb_en = 1'b1; inv_all = 1'b0;
        lkup_vld = 1'b0; lkup_tag = '0; upd_vld = 1'b0; upd_tag = '0; upd_target = '0;
        upd_way_pred = '0; upd_ras = 1'b0; upd_taken = 1'b0;
        tick();
        tick();
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs); end
        cpurst = 1'b0;
        model_reset();
        lookup('h1234);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_lookup_miss got=%h exp=0", obs); end
    endtask

    task automatic test_alloc();
        logic [RW-1:0] exp_c;
        exp_c = {1'b1, IDX_W'(0), TGT_W'('h12345), WAY_W'(2), 1'b0, 1'b1};
        update('h0ABC, 'h12345, 2, 0, 1);
        lookup('h0ABC);
        checks++;
        if (obs !== exp_c) begin errors++; $display("FAIL alloc_first got=%h exp=%h", obs, exp_c); end
        checks++;
        if (obs !== exp_lkup('h0ABC)) begin errors++; $display("FAIL alloc_model got=%h exp=%h", obs, exp_lkup('h0ABC)); end
    endtask

    task automatic test_counter();
        for (int k = 0; k < 3; k++) update('h0ABC, 'h12345, 2, 0, 1);
        lookup('h0ABC);
        checks++;
        if (obs !== exp_lkup('h0ABC) || m_cnt[0] != 3) begin
            errors++; $display("FAIL cnt_saturate_high got=%h exp=%h", obs, exp_lkup('h0ABC));
        end
        for (int k = 0; k < 4; k++) begin
            update('h0ABC, 'h12345, 2, 0, 0);
            lookup('h0ABC);
            checks++;
            if (obs !== exp_lkup('h0ABC)) begin
                errors++; $display("FAIL cnt_nt_%0d got=%h exp=%h", k, obs, exp_lkup('h0ABC));
            end
        end
        checks++;
        if (lkup_hit !== 1'b1 || lkup_taken !== 1'b0) begin
            errors++; $display("FAIL cnt_floor_still_valid got hit=%b taken=%b exp hit=1 taken=0", lkup_hit, lkup_taken);
        end
    endtask

    task automatic test_func_en();
        update('h0DDD, 'h11111, 1, 1, 1);
        cp0_ifu_l0btb_en = 1'b0;
        update('h0DDD, 'h22222, 3, 0, 0);
        update('h0EEE, 'h33333, 0, 0, 1);
        lookup('h0DDD);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL disabled_lookup got=%h exp=0", obs); end
        cp0_ifu_l0btb_en = 1'b1;
        cp0_ifu_btb_en = 1'b0;
        lookup('h0DDD);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL btb_disabled_lookup got=%h exp=0", obs); end
        cp0_ifu_btb_en = 1'b1;
        lookup('h0DDD);
        checks++;
        if (obs !== exp_lkup('h0DDD) || lkup_target !== TGT_W'('h11111) || lkup_ras !== 1'b1) begin
            errors++; $display("FAIL reenable_original got=%h exp=%h", obs, exp_lkup('h0DDD));
        end
        lookup('h0EEE);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL dropped_alloc got=%h exp=0", obs); end
    endtask

    task automatic test_victim();
        do_reset();
        for (int i = 0; i < NUM_ENTRY; i++) update('h200 + i, 'h1000 + i, i % 4, 0, 1);
        update('h300, 'h5A5A5, 3, 1, 1);
        lookup('h300);
        checks++;
        if (obs !== exp_lkup('h300) || lkup_idx !== IDX_W'(0)) begin
            errors++; $display("FAIL victim_first got=%h exp=%h", obs, exp_lkup('h300));
        end
        lookup('h200);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL victim_evicted got=%h exp=0", obs); end
        for (int i = 0; i < NUM_ENTRY; i++) update('h400 + i, 'h2000 + i, 1, 0, 1);
        update('h500, 'h7777, 0, 0, 1);
        lookup('h500);
        checks++;
        if (obs !== exp_lkup('h500) || lkup_idx !== IDX_W'(1)) begin
            errors++; $display("FAIL victim_wrap got=%h exp=%h", obs, exp_lkup('h500));
        end
    endtask

    task automatic test_inv_collide();
        inv_all = 1'b1;
        lkup_vld = 1'b1; lkup_tag = TAG_W'('h500);
        upd_vld = 1'b1; upd_tag = TAG_W'('h600); upd_target = TGT_W'('h600);
        upd_way_pred = '0; upd_ras = 1'b0; upd_taken = 1'b1;
        tick();
        inv_all = 1'b0; lkup_vld = 1'b0; upd_vld = 1'b0;
        model_invalidate();
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL inv_same_cycle_lookup got=%h exp=0", obs); end
        lookup('h500);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL inv_old_tag got=%h exp=0", obs); end
        lookup('h600);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL inv_dropped_upd got=%h exp=0", obs); end
        update('h700, 'h0BEEF, 2, 0, 1);
        lookup('h700);
        checks++;
        if (obs !== exp_lkup('h700) || lkup_idx !== IDX_W'(0)) begin
            errors++; $display("FAIL inv_realloc_idx0 got=%h exp=%h", obs, exp_lkup('h700));
        end
    endtask

    task automatic test_random();
        logic [RW-1:0] exp_r;
        int ltag, utag, utgt, uway;
        bit uras, utaken, do_l, do_u, do_inv, en;
        for (int n = 0; n < 400; n++) begin
            do_l   = ($urandom_range(0, 3) != 0);
            do_u   = ($urandom_range(0, 1) != 0);
            do_inv = ($urandom_range(0, 39) == 0);
            en     = ($urandom_range(0, 9) != 0);
            ltag   = 'h20 + $urandom_range(0, 23);
            utag   = 'h20 + $urandom_range(0, 23);
            utgt   = $urandom_range(0, (1 << TGT_W) - 1);
            uway   = $urandom_range(0, (1 << WAY_W) - 1);
            uras   = $urandom_range(0, 1);
            utaken = ($urandom_range(0, 2) != 0);
            cp0_ifu_l0btb_en = en; inv_all = do_inv;
            lkup_vld = do_l; lkup_tag = TAG_W'(ltag);
            upd_vld = do_u; upd_tag = TAG_W'(utag); upd_target = TGT_W'(utgt);
            upd_way_pred = WAY_W'(uway); upd_ras = uras; upd_taken = utaken;
            exp_r = (do_l && en && !do_inv) ? exp_lkup(ltag) : '0;
            tick();
            if (do_inv) model_invalidate();
            else if (do_u && en) model_update(utag, utgt, uway, uras, utaken);
            checks++;
            if (obs !== exp_r) begin
                errors++; $display("FAIL random_%0d tag=%h got=%h exp=%h", n, ltag, obs, exp_r);
            end
        end
        cp0_ifu_l0btb_en = 1'b1; inv_all = 1'b0; lkup_vld = 1'b0; upd_vld = 1'b0;
    endtask

    task automatic test_mid_reset();
        update('h0F0, 'h0F0F0, 1, 0, 1);
        cpurst = 1'b1;
        lkup_vld = 1'b1; lkup_tag = TAG_W'('h0F0);
        tick();
        cpurst = 1'b0; lkup_vld = 1'b0;
        model_reset();
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL mid_reset_outputs got=%h exp=0", obs); end
        lookup('h0F0);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL mid_reset_lookup got=%h exp=0", obs); end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_func_en();
        test_victim();
        test_inv_collide();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
